// File: rtl/alu_bram32_control.sv
// Execute/memory slice of the rv32i single-cycle core: main control decoder,
// ALU with operand-B mux, and a word-addressed data BRAM with init and debug ports.
module alu_bram32_control #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      instr,
  input  logic [DATA_WIDTH-1:0]            rs1_data,
  input  logic [DATA_WIDTH-1:0]            rs2_data,
  input  logic [DATA_WIDTH-1:0]            imm,
  input  logic                             init_done,
  input  logic [$clog2(MEM_WORDS)+1:0]     init_w_addr,
  input  logic [DATA_WIDTH-1:0]            init_w_dat,
  input  logic                             init_w_enb,
  input  logic [$clog2(MEM_WORDS)+1:0]     debug_addr,
  output logic [DATA_WIDTH-1:0]            debug_data,
  output logic                             branch,
  output logic                             mem_read,
  output logic                             mem_2_reg,
  output logic                             mem_write,
  output logic                             alu_src,
  output logic                             reg_write,
  output logic [1:0]                       imm_src,
  output logic [3:0]                       alu_ctrl,
  output logic [DATA_WIDTH-1:0]            alu_result,
  output logic                             zero,
  output logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [DATA_WIDTH-1:0]            wb_data
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  logic [6:0]                   w_opcode;
  logic [2:0]                   w_func3;
  logic [6:0]                   w_func7;
  alu_op_e                      w_alu_op;
  logic [DATA_WIDTH-1:0]        w_op_b;
  logic signed [DATA_WIDTH-1:0] w_a_s;
  logic signed [DATA_WIDTH-1:0] w_b_s;
  logic [SHW-1:0]               w_shamt;
  logic                         w_we;
  logic [AW-1:0]                w_waddr;
  logic [DATA_WIDTH-1:0]        w_wdata;
  logic                         w_unused;

  logic [DATA_WIDTH-1:0]        r_mem [MEM_WORDS];

  assign w_opcode = instr[6:0];
  assign w_func3  = instr[14:12];
  assign w_func7  = instr[31:25];
  assign w_unused = ^{instr[24:15], instr[11:7], init_w_addr[1:0], debug_addr[1:0]};

  // alt selects SUB for func3 000 and SRA for func3 101
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Control decode
  always_comb begin
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_2_reg = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    imm_src   = 2'b00;
    w_alu_op  = ALU_ADD;
    if (!rst) begin
      case (w_opcode)
        OP_R: begin
          reg_write = 1'b1;
          w_alu_op  = f3_to_op(w_func3, w_func7 == 7'b0100000);
        end
        OP_I: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          // immediate adds have no subtract form; func7[5] matters only for shifts
          w_alu_op  = f3_to_op(w_func3, (w_func3 == 3'b101) && w_func7[5]);
        end
        OP_LOAD: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          mem_read  = 1'b1;
          mem_2_reg = 1'b1;
        end
        OP_STORE: begin
          alu_src   = 1'b1;
          mem_write = 1'b1;
          imm_src   = 2'b01;
        end
        OP_BRANCH: begin
          branch    = 1'b1;
          imm_src   = 2'b10;
          w_alu_op  = ALU_SUB;
        end
        default: ;
      endcase
    end
  end

  assign alu_ctrl = w_alu_op;

  // ALU
  assign w_op_b  = alu_src ? imm : rs2_data;
  assign w_a_s   = $signed(rs1_data);
  assign w_b_s   = $signed(w_op_b);
  assign w_shamt = w_op_b[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (w_alu_op)
      ALU_ADD:  alu_result = rs1_data + w_op_b;
      ALU_SUB:  alu_result = rs1_data - w_op_b;
      ALU_AND:  alu_result = rs1_data & w_op_b;
      ALU_OR:   alu_result = rs1_data | w_op_b;
      ALU_XOR:  alu_result = rs1_data ^ w_op_b;
      ALU_SLL:  alu_result = rs1_data << w_shamt;
      ALU_SRL:  alu_result = rs1_data >> w_shamt;
      ALU_SRA:  alu_result = $unsigned(w_a_s >>> w_shamt);
      ALU_SLT:  alu_result[0] = (w_a_s < w_b_s);
      ALU_SLTU: alu_result[0] = (rs1_data < w_op_b);
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // BRAM write port: init loader until init_done, then the datapath
  always_comb begin
    if (init_done) begin
      w_we    = mem_write;
      w_waddr = alu_result[AW+1:2];
      w_wdata = rs2_data;
    end else begin
      w_we    = init_w_enb;
      w_waddr = init_w_addr[AW+1:2];
      w_wdata = init_w_dat;
    end
    if (rst) w_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign mem_rdata  = mem_read ? r_mem[alu_result[AW+1:2]] : '0;
  assign debug_data = r_mem[debug_addr[AW+1:2]];
  assign wb_data    = mem_2_reg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_alu_bram32_control.sv
// Self-checking bench for alu_bram32_control: directed rv32i cases plus randomized
// instructions compared against a behavioural model with its own memory image.
module tb_alu_bram32_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rs1_data, rs2_data, imm;
  logic        init_done;
  logic [9:0]  init_w_addr;
  logic [31:0] init_w_dat;
  logic        init_w_enb;
  logic [9:0]  debug_addr;
  logic [31:0] debug_data;
  logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
  logic [1:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_rdata, wb_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] load_word [10];

  always #5 clk = ~clk;

  alu_bram32_control #(.DATA_WIDTH(32), .MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .init_done(init_done), .init_w_addr(init_w_addr), .init_w_dat(init_w_dat),
    .init_w_enb(init_w_enb), .debug_addr(debug_addr), .debug_data(debug_data),
    .branch(branch), .mem_read(mem_read), .mem_2_reg(mem_2_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .zero(zero), .mem_rdata(mem_rdata), .wb_data(wb_data)
  );

  typedef struct {
    logic        br, mr, m2r, mw, as, rw;
    logic [1:0]  isrc;
    logic [3:0]  op;
    logic [31:0] res, rdata, wb;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t        e;
    logic [3:0]  f3_tab [8];
    logic [31:0] b;
    logic [2:0]  f3;
    int          sa, sb;
    f3_tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3 = instr[14:12];
    e = '{default: '0};
    if (!rst) begin
      case (instr[6:0])
        7'b0110011: begin
          e.rw = 1;
          e.op = f3_tab[f3];
          if (instr[31:25] == 7'b0100000 && f3 == 3'd0) e.op = 4'd1;
          if (instr[31:25] == 7'b0100000 && f3 == 3'd5) e.op = 4'd7;
        end
        7'b0010011: begin
          e.rw = 1; e.as = 1;
          e.op = f3_tab[f3];
          if (instr[30] && f3 == 3'd5) e.op = 4'd7;
        end
        7'b0000011: begin e.rw = 1; e.as = 1; e.mr = 1; e.m2r = 1; end
        7'b0100011: begin e.as = 1; e.mw = 1; e.isrc = 2'b01; end
        7'b1100011: begin e.br = 1; e.isrc = 2'b10; e.op = 4'd1; end
        default: ;
      endcase
    end
    b  = e.as ? imm : rs2_data;
    sa = rs1_data;
    sb = b;
    case (e.op)
      4'd0: e.res = rs1_data + b;
      4'd1: e.res = rs1_data - b;
      4'd2: e.res = rs1_data & b;
      4'd3: e.res = rs1_data | b;
      4'd4: e.res = rs1_data ^ b;
      4'd5: e.res = rs1_data << b[4:0];
      4'd6: e.res = rs1_data >> b[4:0];
      4'd7: e.res = 32'(sa >>> b[4:0]);
      4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.res = (rs1_data < b) ? 32'd1 : 32'd0;
    endcase
    e.rdata = e.mr ? ref_mem[e.res[9:2]] : 32'd0;
    e.wb    = e.m2r ? e.rdata : e.res;
    return e;
  endfunction

  task automatic check_all(input string tag);
    exp_t e;
    #1;
    e = model();
    chk({tag, ".ctrl"}, {20'd0, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, imm_src, alu_ctrl},
        {20'd0, e.br, e.mr, e.m2r, e.mw, e.as, e.rw, e.isrc, e.op});
    chk({tag, ".alu_result"}, alu_result, e.res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e.res == 32'd0});
    chk({tag, ".mem_rdata"}, mem_rdata, e.rdata);
    chk({tag, ".wb_data"}, wb_data, e.wb);
    chk({tag, ".debug_data"}, debug_data, ref_mem[debug_addr[9:2]]);
  endtask

  // Apply the write the model expects at the coming edge, then move to the next falling edge.
  task automatic tick();
    exp_t e;
    e = model();
    if (!rst) begin
      if (init_done) begin
        if (e.mw) ref_mem[e.res[9:2]] = rs2_data;
      end else if (init_w_enb) begin
        ref_mem[init_w_addr[9:2]] = init_w_dat;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return $urandom % 16;
      2:       return 32'h8000_0000 | ($urandom % 8);
      default: return 32'hFFFF_FFFF - ($urandom % 8);
    endcase
  endfunction

  initial begin
    logic [6:0] ops [6];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};

    rst = 1; instr = 32'h0055_0533; rs1_data = 32'h5; rs2_data = 32'hB; imm = 0;
    init_done = 0; init_w_addr = 0; init_w_dat = 0; init_w_enb = 0; debug_addr = 0;
    @(negedge clk);
    #1;
    chk("reset.ctrl", {20'd0, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, imm_src, alu_ctrl}, 32'd0);
    chk("reset.mem_rdata", mem_rdata, 32'd0);
    chk("reset.alu_result", alu_result, 32'h10);

    // Init load of the whole BRAM; words 0..9 are the known test image.
    rst = 0; instr = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      init_w_addr = 10'(i * 4);
      init_w_dat  = (i == 2) ? 32'h10 : (i < 10) ? (32'hA500_0000 | 32'(i)) : $urandom;
      if (i < 10) load_word[i] = init_w_dat;
      init_w_enb  = 1;
      tick();
    end
    init_w_enb = 0;
    debug_addr = 10'h24;
    check_all("init");
    chk("init.word9", debug_data, load_word[9]);
    tick();

    init_done = 1;
    instr = 32'h0055_0533; rs1_data = 32'h5; rs2_data = 32'hB; imm = 32'h123;
    check_all("add");
    chk("add.reg_write", {31'd0, reg_write}, 32'd1);
    chk("add.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("add.wb_data", wb_data, 32'h10);
    chk("add.zero", {31'd0, zero}, 32'd0);
    tick();

    instr = 32'h0080_2583; rs1_data = 0; rs2_data = 32'h77; imm = 8;
    check_all("lw");
    chk("lw.mem_read", {31'd0, mem_read}, 32'd1);
    chk("lw.mem_2_reg", {31'd0, mem_2_reg}, 32'd1);
    chk("lw.wb_data", wb_data, 32'h10);
    tick();

    instr = {7'd0, 5'd5, 5'd0, 3'b010, 5'd12, 7'b0100011};
    rs1_data = 0; rs2_data = 32'hDEAD_BEEF; imm = 12; debug_addr = 10'd12;
    check_all("sw");
    chk("sw.old_word", debug_data, load_word[3]);
    tick();
    instr = 0;
    check_all("sw_after");
    chk("sw.new_word", debug_data, 32'hDEAD_BEEF);
    tick();

    instr = {7'h20, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}; rs1_data = 0; rs2_data = 1;
    check_all("sub");
    chk("sub.result", alu_result, 32'hFFFF_FFFF);
    tick();
    instr = {7'h00, 5'd3, 5'd2, 3'b010, 5'd1, 7'b0110011}; rs1_data = 32'hFFFF_FFFF; rs2_data = 1;
    check_all("slt");
    chk("slt.result", alu_result, 32'd1);
    tick();
    instr = {7'h00, 5'd3, 5'd2, 3'b011, 5'd1, 7'b0110011};
    check_all("sltu");
    chk("sltu.result", alu_result, 32'd0);
    tick();
    instr = {7'h20, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0110011}; rs1_data = 32'h8000_0000; rs2_data = 4;
    check_all("sra");
    chk("sra.result", alu_result, 32'hF800_0000);
    tick();
    instr = {7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011}; rs1_data = 32'h1234; rs2_data = 32'h1234;
    check_all("beq");
    chk("beq.zero", {31'd0, zero}, 32'd1);
    tick();

    // Reset raised mid-cycle over a pending store.
    instr = {7'd0, 5'd5, 5'd0, 3'b010, 5'd16, 7'b0100011};
    rs1_data = 0; rs2_data = 32'hCAFE_BABE; imm = 16; debug_addr = 10'd16;
    check_all("rst_pre");
    #2 rst = 1;
    check_all("rst_mid");
    chk("rst.ctrl", {20'd0, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, imm_src, alu_ctrl}, 32'd0);
    chk("rst.mem_rdata", mem_rdata, 32'd0);
    tick();
    rst = 0; instr = 0;
    check_all("rst_post");
    chk("rst.word4", debug_data, load_word[4]);
    for (int i = 0; i < 10; i++) begin
      debug_addr = 10'(i * 4);
      #1;
      chk("rst.image", debug_data, (i == 3) ? 32'hDEAD_BEEF : load_word[i]);
    end
    tick();

    for (int n = 0; n < 300; n++) begin
      instr = $urandom;
      instr[6:0] = ops[$urandom % 6];
      if (instr[6:0] == 7'b0110011) instr[31:25] = ($urandom % 2) ? 7'h20 : 7'h00;
      rs1_data = pick();
      rs2_data = ($urandom % 4 == 0) ? rs1_data : pick();
      imm = pick();
      debug_addr = 10'($urandom);
      init_w_enb = 1'($urandom);
      init_w_addr = 10'($urandom);
      init_w_dat = $urandom;
      check_all("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
